// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: oversampled START/STOP/address detection,
// byte shifting, ACK generation and hold-delayed SDA pad control.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         HOLD_CYC   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  input  logic [7:0] TX_DATA,
  output logic       TX_LOAD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ADDR_HIT,
  output logic       RW,
  output logic       BUSY
);

  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t          state;
  logic [2:0]      scl_s, sda_s;
  logic [2:0]      bit_cnt;
  logic            full;
  logic [7:0]      shreg, txsh;
  logic            nack;
  logic            hold_pend, hold_val;
  logic [HW-1:0]   hold_cnt;
  logic            scl_rise, scl_fall, start, stop, match;
  logic            fall_sched, fall_val;

  // Idle bus is high, so syncs reset to 1 to avoid phantom edges
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], SCL_IN};
      sda_s <= {sda_s[1:0], SDA_IN};
    end
  end

  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start    = ~sda_s[1] & sda_s[2] & scl_s[1];
  assign stop     = sda_s[1] & ~sda_s[2] & scl_s[1];
  assign match    = shreg[7:1] == SLAVE_ADDR;

  // Value to present after the current SCL fall, if any
  always_comb begin
    fall_sched = 1'b0;
    fall_val   = 1'b1;
    unique case (state)
      ADDR: begin
        fall_sched = full;
        fall_val   = ~match;
      end
      ADDR_ACK: begin
        fall_sched = 1'b1;
        fall_val   = RW ? TX_DATA[7] : 1'b1;
      end
      WR_BYTE: begin
        fall_sched = full;
        fall_val   = 1'b0;
      end
      WR_ACK: fall_sched = 1'b1;
      RD_BYTE: begin
        fall_sched = 1'b1;
        fall_val   = full ? 1'b1 : txsh[7];
      end
      RD_ACK: begin
        fall_sched = full;
        fall_val   = nack ? 1'b1 : TX_DATA[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      full      <= 1'b0;
      shreg     <= '0;
      txsh      <= '0;
      nack      <= 1'b0;
      hold_pend <= 1'b0;
      hold_val  <= 1'b1;
      hold_cnt  <= '0;
      SDA_OUT   <= 1'b1;
      TX_LOAD   <= 1'b0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      ADDR_HIT  <= 1'b0;
      RW        <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      TX_LOAD  <= 1'b0;
      RX_VALID <= 1'b0;
      ADDR_HIT <= 1'b0;
      if (start || stop) begin
        state     <= start ? ADDR : IDLE;
        BUSY      <= start;
        bit_cnt   <= '0;
        full      <= 1'b0;
        hold_pend <= 1'b0;
        SDA_OUT   <= 1'b1;
      end else begin
        if (hold_pend) begin
          if (hold_cnt == '0) begin
            SDA_OUT   <= hold_val;
            hold_pend <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        if (scl_rise) begin
          unique case (state)
            ADDR, WR_BYTE: begin
              shreg   <= {shreg[6:0], sda_s[1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) full <= 1'b1;
            end
            RD_BYTE: begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) full <= 1'b1;
            end
            RD_ACK: begin
              nack <= sda_s[1];
              full <= 1'b1;
            end
            default: ;
          endcase
        end else if (scl_fall) begin
          if (fall_sched) begin
            hold_val  <= fall_val;
            hold_cnt  <= HOLD_LD;
            hold_pend <= 1'b1;
          end
          unique case (state)
            ADDR: if (full) begin
              full <= 1'b0;
              if (match) begin
                ADDR_HIT <= 1'b1;
                RW       <= shreg[0];
                state    <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
            ADDR_ACK: begin
              bit_cnt <= '0;
              full    <= 1'b0;
              if (RW) begin
                TX_LOAD <= 1'b1;
                txsh    <= {TX_DATA[6:0], 1'b0};
                state   <= RD_BYTE;
              end else begin
                state <= WR_BYTE;
              end
            end
            WR_BYTE: if (full) begin
              full     <= 1'b0;
              RX_DATA  <= shreg;
              RX_VALID <= 1'b1;
              state    <= WR_ACK;
            end
            WR_ACK: state <= WR_BYTE;
            RD_BYTE: begin
              if (full) begin
                full  <= 1'b0;
                state <= RD_ACK;
              end else begin
                txsh <= {txsh[6:0], 1'b0};
              end
            end
            RD_ACK: if (full) begin
              full <= 1'b0;
              if (nack) begin
                state <= IGNORE;
              end else begin
                TX_LOAD <= 1'b1;
                txsh    <= {TX_DATA[6:0], 1'b0};
                bit_cnt <= '0;
                state   <= RD_BYTE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
